// File: rtl/traffic_phase_arbiter.sv
// Round-robin green-phase scheduler for a four-way intersection with min/max green,
// yellow and all-red clearance timing. Emergency preemption is enabled by EMERGENCY_PREEMPT_EN.
module traffic_phase_arbiter #(
    parameter int GREEN_MIN = 4,
    parameter int GREEN_MAX = 15,
    parameter int YELLOW_T  = 3,
    parameter int ALLRED_T  = 2,
    parameter int CW        = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    input  logic       emg_req,
    input  logic [1:0] emg_dir,
    output logic [2:0] north_light,
    output logic [2:0] west_light,
    output logic [2:0] south_light,
    output logic [2:0] east_light,
    output logic [1:0] active_dir,
    output logic       phase_done
);

    // state   | meaning
    // ALL_RED | clearance, all approaches red; grants the next green on exit
    // GREEN   | cur_dir owns the phase
    // YELLOW  | cur_dir is clearing, fixed duration
    typedef enum logic [1:0] {
        ALL_RED = 2'd0,
        GREEN   = 2'd1,
        YELLOW  = 2'd2
    } state_t;

    localparam logic [2:0] LAMP_G = 3'b001;
    localparam logic [2:0] LAMP_Y = 3'b010;
    localparam logic [2:0] LAMP_R = 3'b100;

    localparam logic [CW-1:0] ALLRED_LAST = CW'(ALLRED_T - 1);
    localparam logic [CW-1:0] YELLOW_LAST = CW'(YELLOW_T - 1);
    localparam logic [CW-1:0] GMIN_LAST   = CW'(GREEN_MIN - 1);
    localparam logic [CW-1:0] GMAX_LAST   = CW'(GREEN_MAX - 1);

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic [1:0]    cur_dir;
    logic [1:0]    cur_dir_nxt;
    logic          phase_done_nxt;

    logic [3:0]    dir_mask;
    logic [3:0]    others;
    logic [1:0]    rr_cand;
    logic [1:0]    rr_dir;
    logic          rr_hit;
    logic          emg_preempt;
    logic          emg_hold;
    logic          emg_grant;
    logic          green_exit;
    logic [2:0]    lamp [4];

`ifdef EMERGENCY_PREEMPT_EN
    assign emg_preempt = emg_req && (emg_dir != cur_dir);
    assign emg_hold    = emg_req && (emg_dir == cur_dir);
    assign emg_grant   = emg_req;
`else
    logic emg_unused;
    assign emg_unused  = ^{emg_req, emg_dir};
    assign emg_preempt = 1'b0;
    assign emg_hold    = 1'b0;
    assign emg_grant   = 1'b0;
`endif

    assign dir_mask = 4'b0001 << cur_dir;
    assign others   = req & ~dir_mask;

    // Search order starts just after the last owner, so the last owner is considered last.
    always_comb begin
        rr_dir  = cur_dir;
        rr_hit  = 1'b0;
        rr_cand = cur_dir;
        for (int k = 1; k <= 4; k++) begin
            rr_cand = cur_dir + 2'(k);
            if (!rr_hit && req[rr_cand]) begin
                rr_hit = 1'b1;
                rr_dir = rr_cand;
            end
        end
    end

    assign green_exit = emg_preempt ||
                        (!emg_hold && (others != 4'b0000) &&
                         ((cnt == GMAX_LAST) || ((cnt >= GMIN_LAST) && !req[cur_dir])));

    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        cur_dir_nxt    = cur_dir;
        phase_done_nxt = 1'b0;
        case (state)
            ALL_RED: begin
                if (cnt >= ALLRED_LAST) begin
                    if (emg_grant) begin
                        state_nxt   = GREEN;
                        cnt_nxt     = '0;
                        cur_dir_nxt = emg_dir;
                    end else if (rr_hit) begin
                        state_nxt   = GREEN;
                        cnt_nxt     = '0;
                        cur_dir_nxt = rr_dir;
                    end else begin
                        cnt_nxt = ALLRED_LAST;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            GREEN: begin
                if (green_exit) begin
                    state_nxt = YELLOW;
                    cnt_nxt   = '0;
                end else if (cnt < GMAX_LAST) begin
                    cnt_nxt = cnt + 1'b1;
                end else begin
                    cnt_nxt = GMAX_LAST;
                end
            end
            YELLOW: begin
                if (cnt >= YELLOW_LAST) begin
                    state_nxt      = ALL_RED;
                    cnt_nxt        = '0;
                    phase_done_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = ALL_RED;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ALL_RED;
            cnt        <= '0;
            cur_dir    <= 2'd3;
            phase_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            cur_dir    <= cur_dir_nxt;
            phase_done <= phase_done_nxt;
        end
    end

    // Lamps depend only on registered state, so at most one approach is ever non-red.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            lamp[i] = LAMP_R;
        end
        case (state)
            GREEN:   lamp[cur_dir] = LAMP_G;
            YELLOW:  lamp[cur_dir] = LAMP_Y;
            default: ;
        endcase
    end

    assign north_light = lamp[0];
    assign west_light  = lamp[1];
    assign south_light = lamp[2];
    assign east_light  = lamp[3];
    assign active_dir  = cur_dir;

endmodule

// File: tb/tb_traffic_phase_arbiter.sv
// Scoreboard bench for traffic_phase_arbiter: stimulus pushes hand-computed per-cycle
// lamp/dir/done expectations, a negedge monitor pops and compares them.
module tb_traffic_phase_arbiter;

    localparam logic [11:0] ALLR = 12'b100_100_100_100;
    localparam logic [11:0] NG   = 12'b001_100_100_100;
    localparam logic [11:0] NY   = 12'b010_100_100_100;
    localparam logic [11:0] WG   = 12'b100_001_100_100;
    localparam logic [11:0] WY   = 12'b100_010_100_100;
    localparam logic [11:0] SG   = 12'b100_100_001_100;
    localparam logic [11:0] SY   = 12'b100_100_010_100;
    localparam logic [11:0] EG   = 12'b100_100_100_001;
    localparam logic [11:0] EY   = 12'b100_100_100_010;

    typedef struct {
        string       tag;
        logic [11:0] lamps;
        logic [1:0]  dir;
        logic        pd;
    } exp_t;

    logic       clk;
    logic       reset;
    logic [3:0] req;
    logic       emg_req;
    logic [1:0] emg_dir;
    logic [2:0] north_light, west_light, south_light, east_light;
    logic [1:0] active_dir;
    logic       phase_done;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [11:0] mon_got;
    int          n_checks = 0;
    int          n_fail   = 0;

    traffic_phase_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .emg_req    (emg_req),
        .emg_dir    (emg_dir),
        .north_light(north_light),
        .west_light (west_light),
        .south_light(south_light),
        .east_light (east_light),
        .active_dir (active_dir),
        .phase_done (phase_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e   = exp_q.pop_front();
            mon_got = {north_light, west_light, south_light, east_light};
            n_checks++;
            if (mon_got !== mon_e.lamps || active_dir !== mon_e.dir || phase_done !== mon_e.pd) begin
                n_fail++;
                $display("FAIL %s: got lamps=%b dir=%0d done=%b, expected lamps=%b dir=%0d done=%b",
                         mon_e.tag, mon_got, active_dir, phase_done,
                         mon_e.lamps, mon_e.dir, mon_e.pd);
            end
        end
    end

    // Inputs set before a call are sampled at the next edge; the expectation is for the cycle after it.
    task automatic ticks(input string tag, input int n, input logic [11:0] l,
                         input logic [1:0] d, input logic p);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            e.tag   = tag;
            e.lamps = l;
            e.dir   = d;
            e.pd    = p;
            exp_q.push_back(e);
        end
    endtask

    initial begin
        reset   = 1'b1;
        req     = 4'b0000;
        emg_req = 1'b0;
        emg_dir = 2'd0;

        // reset then north alone: red for two cycles, then north green indefinitely
        ticks("t1_reset", 3, ALLR, 2'd3, 1'b0);
        reset = 1'b0;
        req   = 4'b0001;
        ticks("t1_red", 1, ALLR, 2'd3, 1'b0);
        ticks("t1_north_rest", 20, NG, 2'd0, 1'b0);

        // north and south both holding: north runs to max green
        reset = 1'b1;
        req   = 4'b0101;
        ticks("t2_reset", 2, ALLR, 2'd3, 1'b0);
        reset = 1'b0;
        ticks("t2_red", 1, ALLR, 2'd3, 1'b0);
        ticks("t2_north_max", 15, NG, 2'd0, 1'b0);
        ticks("t2_north_yel", 3, NY, 2'd0, 1'b0);
        ticks("t2_done", 1, ALLR, 2'd0, 1'b1);
        ticks("t2_clear", 1, ALLR, 2'd0, 1'b0);
        ticks("t2_south", 2, SG, 2'd2, 1'b0);

        // north drops on green cycle 1, west asks: exit at min green
        reset = 1'b1;
        req   = 4'b0001;
        ticks("t3_reset", 2, ALLR, 2'd3, 1'b0);
        reset = 1'b0;
        ticks("t3_red", 1, ALLR, 2'd3, 1'b0);
        ticks("t3_north_early", 2, NG, 2'd0, 1'b0);
        req = 4'b0010;
        ticks("t3_north_min", 2, NG, 2'd0, 1'b0);
        ticks("t3_north_yel", 3, NY, 2'd0, 1'b0);
        ticks("t3_done", 1, ALLR, 2'd0, 1'b1);
        ticks("t3_clear", 1, ALLR, 2'd0, 1'b0);
        ticks("t3_west", 2, WG, 2'd1, 1'b0);

        // west and east alternate, north never granted
        reset = 1'b1;
        req   = 4'b0001;
        ticks("t4_reset", 2, ALLR, 2'd3, 1'b0);
        reset = 1'b0;
        ticks("t4_red", 1, ALLR, 2'd3, 1'b0);
        ticks("t4_north0", 1, NG, 2'd0, 1'b0);
        req = 4'b1010;
        ticks("t4_north_min", 3, NG, 2'd0, 1'b0);
        ticks("t4_north_yel", 3, NY, 2'd0, 1'b0);
        ticks("t4_done_n", 1, ALLR, 2'd0, 1'b1);
        ticks("t4_clear_n", 1, ALLR, 2'd0, 1'b0);
        ticks("t4_west1", 15, WG, 2'd1, 1'b0);
        ticks("t4_west1_yel", 3, WY, 2'd1, 1'b0);
        ticks("t4_done_w", 1, ALLR, 2'd1, 1'b1);
        ticks("t4_clear_w", 1, ALLR, 2'd1, 1'b0);
        ticks("t4_east", 15, EG, 2'd3, 1'b0);
        ticks("t4_east_yel", 3, EY, 2'd3, 1'b0);
        ticks("t4_done_e", 1, ALLR, 2'd3, 1'b1);
        ticks("t4_clear_e", 1, ALLR, 2'd3, 1'b0);
        ticks("t4_west2", 2, WG, 2'd1, 1'b0);

        // emergency request for south while west is green at cnt 1
        reset = 1'b1;
        req   = 4'b0010;
        ticks("t5_reset", 2, ALLR, 2'd3, 1'b0);
        reset = 1'b0;
        ticks("t5_red", 1, ALLR, 2'd3, 1'b0);
        ticks("t5_west", 2, WG, 2'd1, 1'b0);
        emg_req = 1'b1;
        emg_dir = 2'd2;
`ifdef EMERGENCY_PREEMPT_EN
        ticks("t5_preempt_yel", 3, WY, 2'd1, 1'b0);
        ticks("t5_done", 1, ALLR, 2'd1, 1'b1);
        ticks("t5_clear", 1, ALLR, 2'd1, 1'b0);
        ticks("t5_south_hold", 20, SG, 2'd2, 1'b0);
`else
        ticks("t5_west_keeps", 25, WG, 2'd1, 1'b0);
`endif
        emg_req = 1'b0;

        // reset during south yellow cycle 1
        reset = 1'b1;
        req   = 4'b0100;
        ticks("t6_reset", 2, ALLR, 2'd3, 1'b0);
        reset = 1'b0;
        ticks("t6_red", 1, ALLR, 2'd3, 1'b0);
        ticks("t6_south0", 1, SG, 2'd2, 1'b0);
        req = 4'b0001;
        ticks("t6_south_min", 3, SG, 2'd2, 1'b0);
        ticks("t6_south_yel", 2, SY, 2'd2, 1'b0);
        reset = 1'b1;
        ticks("t6_mid_reset", 2, ALLR, 2'd3, 1'b0);
        reset = 1'b0;
        req   = 4'b0101;
        ticks("t6_red_after", 1, ALLR, 2'd3, 1'b0);
        ticks("t6_north_first", 2, NG, 2'd0, 1'b0);

        for (int i = 0; i < 4 && exp_q.size() > 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (exp_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
